// File: rtl/axi_lite_arbiter_2m.sv
// Two-master, one-slave AXI4-Lite arbiter: round-robin at transaction granularity, one transaction in flight.
// Optional AXI_ARB_INSN_PRIO_EN: an instruction fetch (arprot[2]=1) beats a data request from the other master.
module axi_lite_arbiter_2m #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              s_awvalid,
    output logic [1:0]              s_awready,
    input  logic [2*ADDR_W-1:0]     s_awaddr,
    input  logic [5:0]              s_awprot,
    input  logic [1:0]              s_wvalid,
    output logic [1:0]              s_wready,
    input  logic [2*DATA_W-1:0]     s_wdata,
    input  logic [2*(DATA_W/8)-1:0] s_wstrb,
    output logic [1:0]              s_bvalid,
    input  logic [1:0]              s_bready,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    input  logic [2*ADDR_W-1:0]     s_araddr,
    input  logic [5:0]              s_arprot,
    output logic [1:0]              s_rvalid,
    input  logic [1:0]              s_rready,
    output logic [2*DATA_W-1:0]     s_rdata,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_W-1:0]       m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_W-1:0]       m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_W-1:0]       m_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } state_t;

    state_t     state;
    logic       grant;
    logic       rr_next;
    logic       aw_done;
    logic       w_done;
    logic [1:0] req;
    logic       winner;
    logic       aw_hs;
    logic       w_hs;
    logic       ar_hs;
    logic       r_hs;
    logic       b_hs;

    assign req = s_arvalid | s_awvalid | s_wvalid;

`ifdef AXI_ARB_INSN_PRIO_EN
    logic [1:0] insn;
    assign insn = {s_arvalid[1] & s_arprot[5], s_arvalid[0] & s_arprot[2]};

    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            if (insn == 2'b01)
                winner = 1'b0;
            else if (insn == 2'b10)
                winner = 1'b1;
            else
                winner = rr_next;
        end
    end
`else
    always_comb begin
        winner = req[1];
        if (req == 2'b11)
            winner = rr_next;
    end
`endif

    // Payload is a plain mux on the registered grant; valids below keep it invisible when not granted.
    assign m_awaddr = grant ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
    assign m_awprot = grant ? s_awprot[5:3] : s_awprot[2:0];
    assign m_wdata  = grant ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
    assign m_wstrb  = grant ? s_wstrb[2*STRB_W-1:STRB_W] : s_wstrb[STRB_W-1:0];
    assign m_araddr = grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    assign m_arprot = grant ? s_arprot[5:3] : s_arprot[2:0];
    assign s_rdata  = {m_rdata, m_rdata};

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;
    assign b_hs  = m_bvalid & m_bready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr_next <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= winner;
                        state <= s_arvalid[winner] ? RADDR : WADDR;
                    end
                end
                RADDR: if (ar_hs) state <= RDATA;
                RDATA: begin
                    if (r_hs) begin
                        rr_next <= ~grant;
                        state   <= IDLE;
                    end
                end
                WADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done | aw_hs) && (w_done | w_hs))
                        state <= WRESP;
                end
                WRESP: begin
                    if (b_hs) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        rr_next <= ~grant;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Done flags stop a master that keeps AW/W high from being forwarded twice.
    always_comb begin
        m_arvalid = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        s_arready = 2'b00;
        s_awready = 2'b00;
        s_wready  = 2'b00;
        s_bvalid  = 2'b00;
        s_rvalid  = 2'b00;
        case (state)
            RADDR: begin
                m_arvalid        = s_arvalid[grant];
                s_arready[grant] = m_arready;
            end
            RDATA: begin
                s_rvalid[grant] = m_rvalid;
                m_rready        = s_rready[grant];
            end
            WADDR: begin
                m_awvalid        = s_awvalid[grant] & ~aw_done;
                s_awready[grant] = m_awready & ~aw_done;
                m_wvalid         = s_wvalid[grant] & ~w_done;
                s_wready[grant]  = m_wready & ~w_done;
            end
            WRESP: begin
                s_bvalid[grant] = m_bvalid;
                m_bready        = s_bready[grant];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter_2m.sv
// Bench for axi_lite_arbiter_2m: directed master stimulus, delay-programmable slave model, queue scoreboard.
module tb_axi_lite_arbiter_2m;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]      s_arvalid, s_arready, s_rvalid, s_rready;
    logic [2*AW-1:0] s_awaddr, s_araddr;
    logic [5:0]      s_awprot, s_arprot;
    logic [2*DW-1:0] s_wdata, s_rdata;
    logic [7:0]      s_wstrb;
    logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic            m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic [2:0]      m_awprot, m_arprot;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [3:0]      m_wstrb;

    axi_lite_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
    );

    typedef struct {
        bit          is_b;
        bit          master;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    // Slave model: programmable handshake delays, word memory, one transaction at a time.
    int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit          r_pend, aw_got, w_got, b_pend;
    bit          mem_loaded = 1'b0;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_strb;
    int          wr_count = 0;
    int          w_hs_count = 0;
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[0]   = 32'h1234_5678;
            mem[64]  = 32'hDEAD_BEEF;
            mem[128] = 32'h2222_0000;
            mem[192] = 32'h3333_1111;
            mem_loaded <= 1'b1;
        end
        if (!resetn) begin
            m_arready <= 1'b0; m_awready <= 1'b0; m_wready <= 1'b0;
            m_rvalid <= 1'b0; m_bvalid <= 1'b0; m_rdata <= 32'h0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
        end else begin
            if (m_arvalid && m_arready) begin
                m_arready <= 1'b0; rd_addr <= m_araddr; r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
            end else if (m_arvalid && !m_arready && !r_pend && !b_pend) begin
                if (ar_cnt >= ar_delay) m_arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
            end
            if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0; r_pend <= 1'b0;
            end else if (r_pend && !m_rvalid) begin
                if (r_cnt >= r_delay) begin
                    m_rvalid <= 1'b1; m_rdata <= mem[rd_addr[9:2]];
                end else r_cnt <= r_cnt + 1;
            end
            if (m_awvalid && m_awready) begin
                m_awready <= 1'b0; wr_addr <= m_awaddr; aw_got <= 1'b1; aw_cnt <= 0;
            end else if (m_awvalid && !m_awready && !aw_got && !b_pend) begin
                if (aw_cnt >= aw_delay) m_awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
            end
            if (m_wvalid && m_wready) begin
                m_wready <= 1'b0; wr_data <= m_wdata; wr_strb <= m_wstrb; w_got <= 1'b1; w_cnt <= 0;
                w_hs_count <= w_hs_count + 1;
            end else if (m_wvalid && !m_wready && !w_got && !b_pend) begin
                if (w_cnt >= w_delay) m_wready <= 1'b1; else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !b_pend) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_addr[9:2]][b*8 +: 8] = wr_data[b*8 +: 8];
                wr_count <= wr_count + 1;
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0; b_pend <= 1'b0;
            end else if (b_pend && !m_bvalid) begin
                if (b_cnt >= b_delay) m_bvalid <= 1'b1; else b_cnt <= b_cnt + 1;
            end
        end
    end

    // Master-side bookkeeping
    bit rd_wait [2];
    bit b_wait  [2];
    bit sticky  [2];
    int rhold   [2];
    int cyc;
    int first_valid_cyc;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sb_check(input bit is_b, input int m, input logic [31:0] data);
        exp_t e;
        checkOutput("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput("sb_kind", 64'(is_b), 64'(e.is_b));
            checkOutput("sb_master", 64'(m), 64'(e.master));
            if (!is_b) checkOutput("r_data", 64'(data), 64'(e.data));
        end
    endtask

    task automatic clear_masters();
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        s_awaddr = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
        for (int i = 0; i < 2; i++) begin
            rd_wait[i] = 1'b0; b_wait[i] = 1'b0; sticky[i] = 1'b0; rhold[i] = 0;
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput(tag, 64'({m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready,
                              s_arready, s_awready, s_wready, s_bvalid, s_rvalid}), 64'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_masters();
        @(posedge clk);
        @(negedge clk);
        checkZero("reset_outputs");
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic issue_read(input int m, input logic [31:0] addr, input logic [2:0] prot,
                              input int hold, input logic [31:0] data);
        exp_t e;
        s_arvalid[m] = 1'b1;
        s_araddr[m*AW +: AW] = addr;
        s_arprot[m*3 +: 3] = prot;
        s_rready[m] = (hold == 0);
        rd_wait[m] = 1'b1;
        rhold[m] = hold;
        e.is_b = 1'b0; e.master = m[0]; e.data = data;
        sb.push_back(e);
    endtask

    task automatic issue_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit hold_valid);
        exp_t e;
        s_awvalid[m] = 1'b1; s_awaddr[m*AW +: AW] = addr; s_awprot[m*3 +: 3] = 3'b000;
        s_wvalid[m] = 1'b1;  s_wdata[m*DW +: DW] = data;  s_wstrb[m*4 +: 4] = strb;
        s_bready[m] = 1'b1;
        b_wait[m] = 1'b1;
        sticky[m] = hold_valid;
        e.is_b = 1'b1; e.master = m[0]; e.data = 32'h0;
        sb.push_back(e);
    endtask

    function automatic bit busy();
        return rd_wait[0] | rd_wait[1] | b_wait[0] | b_wait[1] | (|s_arvalid) | (|s_awvalid) | (|s_wvalid);
    endfunction

    // Cycle engine: sample at negedge, scoreboard handshakes, update master drives just after posedge.
    task automatic applyStimulus(input int budget);
        int n;
        n = 0;
        cyc = 0;
        first_valid_cyc = -1;
        while (busy() && n < budget) begin
            bit [1:0] drop_ar, drop_aw, drop_w, drop_r, drop_b, raise_r;
            drop_ar = '0; drop_aw = '0; drop_w = '0; drop_r = '0; drop_b = '0; raise_r = '0;
            @(negedge clk);
            if (first_valid_cyc < 0 && (m_arvalid || m_awvalid || m_wvalid)) first_valid_cyc = cyc;
            checkOutput("rvalid_gate", 64'(s_rvalid & ~{2{m_rvalid}}), 64'd0);
            checkOutput("bvalid_gate", 64'(s_bvalid & ~{2{m_bvalid}}), 64'd0);
            checkOutput("rvalid_unexpected", 64'(s_rvalid & ~{rd_wait[1], rd_wait[0]}), 64'd0);
            checkOutput("bvalid_unexpected", 64'(s_bvalid & ~{b_wait[1], b_wait[0]}), 64'd0);
            checkOutput("onehot", 64'({$onehot0(s_arready), $onehot0(s_awready), $onehot0(s_wready),
                                       $onehot0(s_rvalid), $onehot0(s_bvalid)}), 64'h1F);
            checkOutput("w_reforward", 64'(w_got & m_wvalid), 64'd0);
            checkOutput("aw_reforward", 64'(aw_got & m_awvalid), 64'd0);
            if (m_arvalid && m_arready)
                checkOutput("ar_overlap", 64'(r_pend | aw_got | w_got | b_pend | m_rvalid | m_bvalid), 64'd0);
            for (int m = 0; m < 2; m++) begin
                if (s_arvalid[m] && s_arready[m]) drop_ar[m] = 1'b1;
                if (s_awvalid[m] && s_awready[m] && !sticky[m]) drop_aw[m] = 1'b1;
                if (s_wvalid[m] && s_wready[m] && !sticky[m]) drop_w[m] = 1'b1;
                if (rd_wait[m] && s_rvalid[m]) begin
                    if (s_rready[m]) begin
                        sb_check(1'b0, m, s_rdata[m*DW +: DW]);
                        drop_r[m] = 1'b1;
                    end else if (rhold[m] > 0) begin
                        checkOutput("rhold_m_rready", 64'(m_rready), 64'd0);
                        checkOutput("rhold_m_rvalid", 64'(m_rvalid), 64'd1);
                        rhold[m]--;
                        if (rhold[m] == 0) raise_r[m] = 1'b1;
                    end
                end
                if (b_wait[m] && s_bvalid[m] && s_bready[m]) begin
                    sb_check(1'b1, m, 32'h0);
                    drop_b[m] = 1'b1;
                    if (sticky[m]) begin drop_aw[m] = 1'b1; drop_w[m] = 1'b1; end
                end
            end
            @(posedge clk);
            #1;
            s_arvalid = s_arvalid & ~drop_ar;
            s_awvalid = s_awvalid & ~drop_aw;
            s_wvalid  = s_wvalid & ~drop_w;
            s_rready  = (s_rready & ~drop_r) | raise_r;
            s_bready  = s_bready & ~drop_b;
            for (int m = 0; m < 2; m++) begin
                if (drop_r[m]) rd_wait[m] = 1'b0;
                if (drop_b[m]) begin b_wait[m] = 1'b0; sticky[m] = 1'b0; end
            end
            cyc++;
            n++;
        end
        checkOutput("run_timeout", 64'(busy()), 64'd0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int wr_before, whs_before;
        ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
        clear_masters();
        $display("[TB] start");
        do_reset();

        // Single M0 read, slave answers 3 cycles late
        r_delay = 3;
        issue_read(0, 32'h0000_0100, 3'b000, 0, 32'hDEAD_BEEF);
        applyStimulus(100);
        checkOutput("t1_latency", 64'(first_valid_cyc), 64'd1);

        // Simultaneous reads twice from reset: M0 then M1 each time
        do_reset();
        r_delay = 1; ar_delay = 1;
        for (int rep = 0; rep < 2; rep++) begin
            issue_read(0, 32'h0000_0200, 3'b000, 0, 32'h2222_0000);
            issue_read(1, 32'h0000_0300, 3'b000, 0, 32'h3333_1111);
            applyStimulus(200);
            checkOutput("t2_latency", 64'(first_valid_cyc), 64'd1);
        end

        // M1 write with W accepted two cycles before AW, master holding valids until B
        ar_delay = 0; aw_delay = 2; w_delay = 0; b_delay = 1;
        wr_before = wr_count; whs_before = w_hs_count;
        issue_write(1, 32'h1000_0000, 32'h0000_55AA, 4'b0011, 1'b1);
        applyStimulus(100);
        checkOutput("t3_latency", 64'(first_valid_cyc), 64'd1);
        checkOutput("t3_mem", 64'(mem[0]), 64'h1234_55AA);
        checkOutput("t3_wr_once", 64'(wr_count - wr_before), 64'd1);
        checkOutput("t3_w_hs_once", 64'(w_hs_count - whs_before), 64'd1);

        // M0 read with rready withheld for 5 cycles of rvalid
        aw_delay = 0; r_delay = 1;
        issue_read(0, 32'h0000_0100, 3'b000, 5, 32'hDEAD_BEEF);
        applyStimulus(100);
        checkOutput("t4_hold_done", 64'(rhold[0]), 64'd0);

        // Reset while in WRESP, then a fresh M1 read
        b_delay = 20;
        issue_write(0, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_pend) break;
        end
        checkOutput("t5_in_wresp", 64'(b_pend), 64'd1);
        checkOutput("t5_bready_before_reset", 64'(m_bready), 64'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkZero("t5_reset_outputs");
        @(posedge clk);
        #1;
        clear_masters();
        sb.delete();
        resetn = 1'b1;
        b_delay = 0;
        issue_read(1, 32'h0000_0300, 3'b000, 0, 32'h3333_1111);
        applyStimulus(100);
        checkOutput("t5_latency", 64'(first_valid_cyc), 64'd1);

        // rr_next is 0: M0 data read against M1 instruction fetch
`ifdef AXI_ARB_INSN_PRIO_EN
        issue_read(1, 32'h0000_0200, 3'b100, 0, 32'h2222_0000);
        issue_read(0, 32'h0000_0100, 3'b000, 0, 32'hDEAD_BEEF);
`else
        issue_read(0, 32'h0000_0100, 3'b000, 0, 32'hDEAD_BEEF);
        issue_read(1, 32'h0000_0200, 3'b100, 0, 32'h2222_0000);
`endif
        applyStimulus(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter_2m.md
Name: axi_lite_arbiter_2m

Overview:
- Two-master, one-slave AXI4-Lite arbiter. Lets two picorv32_axi cores, or a core plus a DMA/debug master, share one memory/peripheral slave such as the bench memory model.
- Round-robin grant at transaction granularity; exactly one transaction (read or write) in flight at a time.
- Sits between the masters' mem_axi_* ports and the single slave port.

Parameters:
- ADDR_W, 32, address width of all AW/AR channels.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s_awvalid/s_awready  in/out  2  per-master AW handshake; bit i = master i
- s_awaddr  in  2*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
- s_awprot  in  6  3 bits per master
- s_wvalid/s_wready  in/out  2  per-master W handshake
- s_wdata  in  2*DATA_W  per-master write data
- s_wstrb  in  2*DATA_W/8  per-master strobes
- s_bvalid/s_bready  out/in  2  per-master B handshake
- s_arvalid/s_arready  in/out  2  per-master AR handshake
- s_araddr  in  2*ADDR_W  per-master read address
- s_arprot  in  6  per-master prot
- s_rvalid/s_rready  out/in  2  per-master R handshake
- s_rdata  out  2*DATA_W  per-master read data; both slices carry m_rdata
- m_awvalid, m_awready, m_awaddr, m_awprot  out/in/out/out  1/1/ADDR_W/3  slave AW
- m_wvalid, m_wready, m_wdata, m_wstrb  out/in/out/out  1/1/DATA_W/DATA_W/8  slave W
- m_bvalid, m_bready  in/out  1/1  slave B
- m_arvalid, m_arready, m_araddr, m_arprot  out/in/out/out  1/1/ADDR_W/3  slave AR
- m_rvalid, m_rready, m_rdata  in/out/in  1/1/DATA_W  slave R

Behaviour:
- Clock clk; reset resetn, synchronous, active-low.
- Reset state: IDLE, grant=0, rr_next=0, aw_done=w_done=0. All valid/ready outputs 0.
- FSM states:
  - IDLE: req[i] = s_arvalid[i] | s_awvalid[i] | s_wvalid[i].
    - If req has any bit set, register grant: rr_next wins when both request, otherwise the sole requester.
    - Within the granted master, read wins if AR and AW/W are both pending.
    - Go to RADDR or WADDR.
    - No channel forwarded in IDLE. Request-to-m_*valid latency is exactly 1 cycle.
  - RADDR: m_arvalid = s_arvalid[grant]; addr/prot muxed from grant; s_arready[grant] = m_arready. On handshake go to RDATA.
  - RDATA: s_rvalid[grant] = m_rvalid; m_rready = s_rready[grant]. On handshake: rr_next = ~grant, go to IDLE.
  - WADDR: AW and W forwarded independently.
    - m_awvalid = s_awvalid[grant] & ~aw_done; m_wvalid = s_wvalid[grant] & ~w_done.
    - aw_done/w_done set on the respective handshake, in either order or the same cycle.
    - When both are done (or complete this cycle), go to WRESP.
  - WRESP: s_bvalid[grant] = m_bvalid; m_bready = s_bready[grant]. On handshake: clear done flags, rr_next = ~grant, go to IDLE.
- Non-granted master: all its ready/valid outputs held 0. Its payload is never visible on m_*.
- Valid/ready paths are combinational through the mux; payload is unregistered. No combinational path from m_*ready to m_*valid.
- Master keeps AW or W valid after its handshake: not forwarded again in this transaction (done flags).
- A master asserting only W with no AW is granted into WADDR and waits there for AW. This is legal AXI ordering.
- Reset mid-transaction: FSM returns to IDLE, outputs drop the next cycle, and the in-flight transaction is abandoned. Slave and masters are reset together system-wide.
- s_rdata: both slices driven from m_rdata; only the granted master sees rvalid.

Optional Feature:
- Macro: AXI_ARB_INSN_PRIO_EN.
- Defined: in IDLE, a master whose s_arvalid is high with s_arprot[i*3+2]=1 (instruction fetch) beats a data request from the other master, regardless of rr_next. Two instruction fetches fall back to round-robin. rr_next still updates normally.
- Undefined: pure round-robin; arprot is passed through only.

Test Plan:
- M0 reads 0x0000_0100, slave returns 0xDEADBEEF after 3 cycles -> m_arvalid 1 cycle after s_arvalid[0]. s_rvalid[0]=1 with s_rdata[31:0]=0xDEADBEEF; s_rvalid[1] stays 0.
- M0 and M1 issue reads the same cycle after reset -> M0 served first, then M1. Repeat -> M0 first again (rr_next=0 after M1). Never two m_arvalid transactions overlap.
- M1 writes 0x55AA to 0x1000_0000, strb 0011; slave asserts wready 2 cycles before awready -> m_wvalid drops after the W handshake. s_bvalid[1] only after m_bvalid; memory updated once.
- M0 holds s_rready=0 for 5 cycles during RDATA -> m_rready=0 for those cycles. m_rvalid is held, and completion happens on the first cycle s_rready=1.
- resetn pulsed low while in WRESP -> next cycle all outputs 0, state IDLE. A fresh M1 read then completes normally.
- With AXI_ARB_INSN_PRIO_EN: rr_next=0, M0 data read and M1 fetch (arprot=100) simultaneously -> M1 granted first. Without the macro, M0 is granted first.
